// File: rtl/vga_timing_gen.sv
// vga_timing_gen: two-mode VGA raster timing generator; VGA_TIMING_FRAME_CNT_EN adds a 16-bit frame counter
module vga_timing_gen #(
  parameter int CW         = 11,
  parameter int A_H_ACTIVE = 640,
  parameter int A_H_FRONT  = 16,
  parameter int A_H_SYNC   = 96,
  parameter int A_H_BACK   = 48,
  parameter int A_V_ACTIVE = 480,
  parameter int A_V_FRONT  = 10,
  parameter int A_V_SYNC   = 2,
  parameter int A_V_BACK   = 33,
  parameter bit A_H_POL    = 1'b0,
  parameter bit A_V_POL    = 1'b0,
  parameter int B_H_ACTIVE = 800,
  parameter int B_H_FRONT  = 40,
  parameter int B_H_SYNC   = 128,
  parameter int B_H_BACK   = 88,
  parameter int B_V_ACTIVE = 600,
  parameter int B_V_FRONT  = 1,
  parameter int B_V_SYNC   = 4,
  parameter int B_V_BACK   = 23,
  parameter bit B_H_POL    = 1'b1,
  parameter bit B_V_POL    = 1'b1
) (
  input  logic          vga_clock,
  input  logic          reset_n,
  input  logic          en,
  input  logic          mode_sel,
  output logic          cur_mode,
  output logic [CW-1:0] hcount,
  output logic [CW-1:0] vcount,
  output logic          hsync,
  output logic          vsync,
  output logic          blank_n,
  output logic          sync_n,
  output logic          line_start,
  output logic          frame_start
`ifdef VGA_TIMING_FRAME_CNT_EN
  ,
  output logic [15:0]   frame_cnt
`endif
);
  localparam logic [CW-1:0] ONE   = CW'(1);
  localparam logic [CW-1:0] A_HA  = CW'(A_H_ACTIVE);
  localparam logic [CW-1:0] A_HSS = CW'(A_H_ACTIVE + A_H_FRONT);
  localparam logic [CW-1:0] A_HSE = CW'(A_H_ACTIVE + A_H_FRONT + A_H_SYNC);
  localparam logic [CW-1:0] A_HM  = CW'(A_H_ACTIVE + A_H_FRONT + A_H_SYNC + A_H_BACK - 1);
  localparam logic [CW-1:0] A_VA  = CW'(A_V_ACTIVE);
  localparam logic [CW-1:0] A_VSS = CW'(A_V_ACTIVE + A_V_FRONT);
  localparam logic [CW-1:0] A_VSE = CW'(A_V_ACTIVE + A_V_FRONT + A_V_SYNC);
  localparam logic [CW-1:0] A_VM  = CW'(A_V_ACTIVE + A_V_FRONT + A_V_SYNC + A_V_BACK - 1);
  localparam logic [CW-1:0] B_HA  = CW'(B_H_ACTIVE);
  localparam logic [CW-1:0] B_HSS = CW'(B_H_ACTIVE + B_H_FRONT);
  localparam logic [CW-1:0] B_HSE = CW'(B_H_ACTIVE + B_H_FRONT + B_H_SYNC);
  localparam logic [CW-1:0] B_HM  = CW'(B_H_ACTIVE + B_H_FRONT + B_H_SYNC + B_H_BACK - 1);
  localparam logic [CW-1:0] B_VA  = CW'(B_V_ACTIVE);
  localparam logic [CW-1:0] B_VSS = CW'(B_V_ACTIVE + B_V_FRONT);
  localparam logic [CW-1:0] B_VSE = CW'(B_V_ACTIVE + B_V_FRONT + B_V_SYNC);
  localparam logic [CW-1:0] B_VM  = CW'(B_V_ACTIVE + B_V_FRONT + B_V_SYNC + B_V_BACK - 1);

  logic [CW-1:0] hcount_q, hcount_d, vcount_q, vcount_d;
  logic          cur_mode_q, cur_mode_d;
  logic [CW-1:0] h_max, h_act, h_ss, h_se, v_max, v_act, v_ss, v_se;
  logic          h_pol, v_pol, h_last, v_last, frame_wrap;

  // Timing constants of the mode currently in effect
  always_comb begin
    h_max = cur_mode_q ? B_HM  : A_HM;
    h_act = cur_mode_q ? B_HA  : A_HA;
    h_ss  = cur_mode_q ? B_HSS : A_HSS;
    h_se  = cur_mode_q ? B_HSE : A_HSE;
    h_pol = cur_mode_q ? B_H_POL : A_H_POL;
    v_max = cur_mode_q ? B_VM  : A_VM;
    v_act = cur_mode_q ? B_VA  : A_VA;
    v_ss  = cur_mode_q ? B_VSS : A_VSS;
    v_se  = cur_mode_q ? B_VSE : A_VSE;
    v_pol = cur_mode_q ? B_V_POL : A_V_POL;
  end

  // Raster counters advance with en; the requested mode is only adopted on the frame wrap
  always_comb begin
    h_last     = hcount_q == h_max;
    v_last     = vcount_q == v_max;
    frame_wrap = en && h_last && v_last;
    hcount_d   = !en ? hcount_q : h_last ? '0 : hcount_q + ONE;
    vcount_d   = !(en && h_last) ? vcount_q : v_last ? '0 : vcount_q + ONE;
    cur_mode_d = frame_wrap ? mode_sel : cur_mode_q;
  end

  // Counter and mode registers
  always_ff @(posedge vga_clock or negedge reset_n)
    if (!reset_n) begin
      hcount_q   <= '0;
      vcount_q   <= '0;
      cur_mode_q <= 1'b0;
    end else begin
      hcount_q   <= hcount_d;
      vcount_q   <= vcount_d;
      cur_mode_q <= cur_mode_d;
    end

  // Zero-latency decode of sync, blanking and strobes from registered state
  always_comb begin
    cur_mode    = cur_mode_q;
    hcount      = hcount_q;
    vcount      = vcount_q;
    hsync       = (hcount_q >= h_ss && hcount_q < h_se) ? h_pol : !h_pol;
    vsync       = (vcount_q >= v_ss && vcount_q < v_se) ? v_pol : !v_pol;
    blank_n     = en && hcount_q < h_act && vcount_q < v_act;
    sync_n      = 1'b0;
    line_start  = en && hcount_q == '0;
    frame_start = en && hcount_q == '0 && vcount_q == '0;
  end

`ifdef VGA_TIMING_FRAME_CNT_EN
  logic [15:0] frame_cnt_q, frame_cnt_d;

  // Frame counter bumps on each frame wrap and rolls over naturally
  always_comb begin
    frame_cnt_d = frame_wrap ? frame_cnt_q + 16'd1 : frame_cnt_q;
    frame_cnt   = frame_cnt_q;
  end

  // Frame counter register
  always_ff @(posedge vga_clock or negedge reset_n)
    if (!reset_n) frame_cnt_q <= '0;
    else frame_cnt_q <= frame_cnt_d;
`endif
endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
Parametrised VGA raster timing generator with two run-time selectable timing modes.
- Mode A defaults to 640x480@60; mode B defaults to 800x600@60.
- Adds a counter-enable input, per-mode sync polarity, line/frame start strobes and glitch-free mode switching at frame boundaries.
- Drives the pixel-address and DAC-control side of the VGA output path. Pixel generators consume hcount/vcount and blank_n in the same cycle.

Parameters:
- CW, 11, width of hcount/vcount; must hold max(H_TOTAL-1, V_TOTAL-1) of both modes
- A_H_ACTIVE, 640, mode A visible pixels per line
- A_H_FRONT, 16, mode A horizontal front porch
- A_H_SYNC, 96, mode A hsync width
- A_H_BACK, 48, mode A horizontal back porch
- A_V_ACTIVE, 480, mode A visible lines
- A_V_FRONT, 10, mode A vertical front porch
- A_V_SYNC, 2, mode A vsync width
- A_V_BACK, 33, mode A vertical back porch
- A_H_POL, 0, mode A hsync asserted level (0 = active-low)
- A_V_POL, 0, mode A vsync asserted level
- B_H_ACTIVE, 800; B_H_FRONT, 40; B_H_SYNC, 128; B_H_BACK, 88; mode B horizontal timing
- B_V_ACTIVE, 600; B_V_FRONT, 1; B_V_SYNC, 4; B_V_BACK, 23; mode B vertical timing
- B_H_POL, 1; B_V_POL, 1; mode B sync asserted levels

Ports:
- vga_clock  in  1  pixel clock
- reset_n  in  1  reset
- en  in  1  counter advance enable
- mode_sel  in  1  requested mode (0 = A, 1 = B)
- cur_mode  out  1  mode currently in effect
- hcount  out  CW  horizontal position
- vcount  out  CW  vertical position
- hsync  out  1  horizontal sync at the mode's polarity
- vsync  out  1  vertical sync at the mode's polarity
- blank_n  out  1  high only in the visible region while en=1
- sync_n  out  1  DAC composite sync, tied 0
- line_start  out  1  one-cycle strobe at the start of each line
- frame_start  out  1  one-cycle strobe at the start of each frame

Behaviour:
Reset and clock:
- Reset reset_n, asynchronous, active-low; clock vga_clock. All flops reset asynchronously.
- Reset values: hcount=0, vcount=0, cur_mode=0.
- Outputs after reset: hsync=!A_H_POL, vsync=!A_V_POL, sync_n=0. blank_n, line_start and frame_start follow en.

Derived totals (per current mode M):
- H_TOTAL = ACTIVE+FRONT+SYNC+BACK for horizontal; V_TOTAL likewise for vertical.

Counters (update only when en=1):
- hcount increments each cycle. At H_TOTAL-1 it wraps to 0.
- vcount increments when hcount wraps. At V_TOTAL-1, on the hcount wrap, it wraps to 0.
- en=0: all counters and cur_mode hold.

Mode switching:
- cur_mode loads mode_sel only on the frame-wrap cycle (en=1, hcount=H_TOTAL-1, vcount=V_TOTAL-1). The new mode takes effect from (0,0) of the next frame.
- mode_sel changes mid-frame, including toggling back before the boundary, have no effect except the value sampled at the wrap.

Combinational outputs (from registered counters and cur_mode, zero latency):
- hsync is at the asserted level iff H_ACTIVE+H_FRONT <= hcount < H_ACTIVE+H_FRONT+H_SYNC. vsync uses the same rule on vcount.
- blank_n = en && hcount < H_ACTIVE && vcount < V_ACTIVE.
- line_start = en && hcount==0.
- frame_start = line_start && vcount==0.

Boundary conditions:
- Reset asserted mid-frame forces (0,0) and mode A immediately, without waiting for a clock edge.
- Counters never exceed the current mode's totals. Sync regions are evaluated against the current mode only.

Optional Feature:
Macro VGA_TIMING_FRAME_CNT_EN.
- Defined:
  - Adds output frame_cnt [15:0], reset 0.
  - frame_cnt increments on every frame-wrap cycle and wraps 65535 -> 0.
  - frame_cnt holds while en=0. It is not cleared by a mode change.
- Undefined: the port and its counter do not exist. All other behaviour is identical.

Test Plan:
1. Reset, en=1, mode_sel=0, run 420000 cycles -> hcount spans 0..799 and vcount spans 0..524. hsync is low exactly at hcount 656..751, vsync low exactly at vcount 490..491. frame_start fires at cycles 0 and 420000.
2. Same run -> blank_n is high for exactly 307200 cycles per frame. line_start fires 525 times per frame.
3. Set mode_sel=1 at vcount=100 -> cur_mode stays 0 until the frame-wrap cycle, then becomes 1. The next frame is 1056x628: hsync high at hcount 840..967, vsync high at vcount 601..604.
4. Drop en for 50 cycles at hcount=300, vcount=20 -> counters hold at (300,20). blank_n, line_start and frame_start are 0 during the hold. Counting resumes at 301.
5. Assert reset_n=0 mid-frame in mode B -> hcount and vcount are 0 and cur_mode is 0 before the next clock edge. hsync and vsync are high (mode A idle level).
6. With VGA_TIMING_FRAME_CNT_EN defined, run 3 frames, then toggle en and mode -> frame_cnt reads 3. It is unchanged during en=0 and not reset by the mode switch.
